// File: rtl/layer_ram_sequencer_if.sv
// Bus bundle between the network controller / RAMs and the per-layer sequencer.
// The slave modport is the sequencer side. The master modport is the controller and RAM side.
interface layer_ram_sequencer_if #(
  parameter int DATA_W   = 16,
  parameter int IN_LOG2  = 3,
  parameter int OUT_LOG2 = 3
);
  logic                           start;
  logic [1:0]                     layer;
  logic                           layer_sel;
  logic                           busy;
  logic                           done;
  logic                           w_rd_en;
  logic [2+OUT_LOG2+IN_LOG2-1:0]  w_addr;
  logic [DATA_W-1:0]              w_data;
  logic                           x_rd_en;
  logic                           x_bank;
  logic [IN_LOG2-1:0]             x_addr;
  logic [DATA_W-1:0]              x_data;
  logic                           y_wr_en;
  logic                           y_bank;
  logic [OUT_LOG2-1:0]            y_addr;
  logic [DATA_W-1:0]              y_data;

  modport slave (
    input  start, layer, layer_sel, w_data, x_data,
    output busy, done, w_rd_en, w_addr, x_rd_en, x_bank, x_addr,
           y_wr_en, y_bank, y_addr, y_data
  );

  modport master (
    output start, layer, layer_sel, w_data, x_data,
    input  busy, done, w_rd_en, w_addr, x_rd_en, x_bank, x_addr,
           y_wr_en, y_bank, y_addr, y_data
  );
endinterface

// File: rtl/layer_ram_sequencer.sv
// One full-layer pass per start pulse: streams weights and activations, does a signed MAC,
// and writes saturated results into the opposite ping-pong activation bank.
module layer_ram_sequencer #(
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 40,
  parameter int IN_LOG2  = 3,
  parameter int OUT_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  layer_ram_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_e;

  localparam logic [IN_LOG2-1:0]  INPUT_LAST  = '1;
  localparam logic [OUT_LOG2-1:0] NEURON_LAST = '1;

  state_e                   state_q, state_d;
  logic [OUT_LOG2-1:0]      neuron_q, neuron_d;
  logic [IN_LOG2-1:0]       input_q, input_d;
  logic [1:0]               layer_q, layer_d;
  logic                     sel_q, sel_d;
  logic                     valid_q, valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic                       fits;
  logic [DATA_W-1:0]          sat_y;

  assign prod     = $signed(bus.w_data) * $signed(bus.x_data);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign shifted  = acc_q >>> FRAC;
  // The result fits when every bit above the result's sign bit copies that sign bit.
  assign fits     = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);
  assign sat_y    = fits ? shifted[DATA_W-1:0]
                  : (shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}});

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    neuron_d     = neuron_q;
    input_d      = input_q;
    layer_d      = layer_q;
    sel_d        = sel_q;
    valid_d      = 1'b0;
    acc_d        = valid_q ? acc_q + prod_ext : acc_q;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.w_rd_en  = 1'b0;
    bus.w_addr   = '0;
    bus.x_rd_en  = 1'b0;
    bus.x_addr   = '0;
    bus.x_bank   = 1'b0;
    bus.y_wr_en  = 1'b0;
    bus.y_bank   = 1'b0;
    bus.y_addr   = '0;
    bus.y_data   = '0;

    if (state_q inside {S_READ, S_DRAIN, S_WRITE}) begin
      bus.busy   = 1'b1;
      bus.x_bank = sel_q;
      bus.y_bank = ~sel_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          layer_d  = bus.layer;
          sel_d    = bus.layer_sel;
          neuron_d = '0;
          input_d  = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        bus.w_rd_en = 1'b1;
        bus.x_rd_en = 1'b1;
        bus.w_addr  = {layer_q, neuron_q, input_q};
        bus.x_addr  = input_q;
        valid_d     = 1'b1;
        input_d     = input_q + 1'b1;
        if (input_q == INPUT_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        bus.y_wr_en = 1'b1;
        bus.y_addr  = neuron_q;
        bus.y_data  = sat_y;
        acc_d       = '0;
        if (neuron_q == NEURON_LAST) begin
          state_d = S_DONE;
        end else begin
          neuron_d = neuron_q + 1'b1;
          input_d  = '0;
          state_d  = S_READ;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      neuron_q <= '0;
      input_q  <= '0;
      layer_q  <= '0;
      sel_q    <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      input_q  <= input_d;
      layer_q  <= layer_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_layer_ram_sequencer.sv
// Scoreboard bench for layer_ram_sequencer: RAM models, a reference neuron model,
// and a monitor that checks every write, done pulse and busy cycle.
module tb_layer_ram_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_ram_sequencer_if bus ();

  layer_ram_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] w_mem [256];
  logic [15:0] x_mem [2][8];

  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= w_mem[bus.w_addr];
    if (bus.x_rd_en) bus.x_data <= x_mem[bus.x_bank][bus.x_addr];
  end

  typedef struct {
    logic        bank;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t       yq[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         in_pass  = 1'b0;
  int         pass_start = -1000;
  logic [1:0] exp_layer = '0;
  logic       exp_sel   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference neuron: plain signed dot product, arithmetic shift, clamp to the 16-bit range.
  function automatic logic [15:0] ref_y(input logic [1:0] l, input logic s, input int n);
    longint acc = 0;
    for (int i = 0; i < 8; i++)
      acc += longint'($signed(w_mem[int'(l) * 64 + n * 8 + i])) * longint'($signed(x_mem[s][i]));
    acc = acc >>> 8;
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return 16'(acc);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    bit   busy_exp;
    exp_t e;
    #1;
    busy_exp = in_pass && (cyc >= pass_start + 1) && (cyc <= pass_start + 80);
    check("busy", bus.busy, busy_exp);
    if (bus.w_rd_en) begin
      if (in_pass) begin
        check("w_addr_layer", bus.w_addr[7:6], exp_layer);
        check("x_bank", bus.x_bank, exp_sel);
      end else begin
        check("stray_read", bus.w_rd_en, 0);
      end
    end
    if (bus.y_wr_en) begin
      if (yq.size() == 0) begin
        check("unexpected_write", bus.y_wr_en, 0);
      end else begin
        e = yq.pop_front();
        check("y_bank", bus.y_bank, e.bank);
        check("y_addr", bus.y_addr, e.addr);
        check("y_data", bus.y_data, e.data);
      end
    end
    if (in_pass && cyc == pass_start + 81) begin
      check("done_cycle", bus.done, 1);
      check("pending_writes", yq.size(), 0);
      in_pass = 1'b0;
    end else if (bus.done) begin
      check("unexpected_done", bus.done, 0);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_done"},    bus.done,    0);
    check({tag, "_w_rd_en"}, bus.w_rd_en, 0);
    check({tag, "_x_rd_en"}, bus.x_rd_en, 0);
    check({tag, "_y_wr_en"}, bus.y_wr_en, 0);
    check({tag, "_y_bank"},  bus.y_bank,  0);
    check({tag, "_w_addr"},  bus.w_addr,  0);
  endtask

  task automatic fill(input int mode, input logic [15:0] wv, input logic [15:0] xv);
    for (int a = 0; a < 256; a++)
      w_mem[a] = (mode == 0) ? wv : (mode == 1) ? 16'($urandom_range(0, 1023)) - 16'd512
                                                : 16'($urandom);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++)
        x_mem[b][i] = (mode == 0) ? xv : (mode == 1) ? 16'($urandom_range(0, 2047)) - 16'd1024
                                                     : 16'($urandom);
  endtask

  task automatic run_layer(input logic [1:0] l, input logic s, input bit disturb, input bit abort);
    int   t0;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    for (int n = 0; n < 8; n++) begin
      e.bank = ~s;
      e.addr = 3'(n);
      e.data = ref_y(l, s, n);
      yq.push_back(e);
    end
    exp_layer  = l;
    exp_sel    = s;
    pass_start = t0;
    in_pass    = 1'b1;
    bus.start     = 1'b1;
    bus.layer     = l;
    bus.layer_sel = s;
    @(negedge clk);
    bus.start = 1'b0;
    while (in_pass && cyc < t0 + 200) begin
      if (disturb && (cyc == t0 + 5 || cyc == t0 + 40)) begin
        bus.start     = 1'b1;
        bus.layer     = ~l;
        bus.layer_sel = ~s;
      end else begin
        bus.start = 1'b0;
      end
      if (abort && cyc == t0 + 20) begin
        reset   = 1'b1;
        in_pass = 1'b0;
        yq.delete();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    check("pass_timeout", in_pass, 0);
    in_pass = 1'b0;
    yq.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.layer     = '0;
    bus.layer_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Unity weights and activations: eight results of 8.0.
    fill(0, 16'h0100, 16'h0100);
    run_layer(2'd0, 1'b0, 1'b0, 1'b0);

    // Saturation at both ends.
    fill(0, 16'h7FFF, 16'h7FFF);
    run_layer(2'd1, 1'b1, 1'b0, 1'b0);
    fill(0, 16'h7FFF, 16'h8000);
    run_layer(2'd1, 1'b0, 1'b0, 1'b0);

    // Layer 2, bank 0, with stray starts and input changes mid-pass.
    fill(1, '0, '0);
    run_layer(2'd2, 1'b0, 1'b1, 1'b0);

    // Reset mid-pass, then a clean rerun.
    fill(2, '0, '0);
    run_layer(2'd3, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("abort");
    run_layer(2'd3, 1'b1, 1'b0, 1'b0);

    // Four back-to-back layers with alternating banks.
    for (int r = 0; r < 2; r++) begin
      fill(r + 1, '0, '0);
      for (int k = 0; k < 4; k++) run_layer(2'(k), k[0], 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
